// File: rtl/core_pkg.sv
// Shared core definitions: multiply-unit state encoding, producer (depend)
// codes and M-extension funct3 codes. Used by mul_unit and the issue scoreboard.
package core_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    MUL_IDLE     = 2'b00,
    MUL_WAIT_OPS = 2'b01,
    MUL_EXEC     = 2'b10,
    MUL_DONE     = 2'b11
  } mul_state_e;

  // Producer of a source operand
  localparam logic [1:0] DEP_NONE = 2'b00;
  localparam logic [1:0] DEP_ALU  = 2'b01;
  localparam logic [1:0] DEP_MUL  = 2'b10;
  localparam logic [1:0] DEP_LSU  = 2'b11;

  // funct3[1:0] of the multiply group
  localparam logic [1:0] F3_MUL    = 2'b00;
  localparam logic [1:0] F3_MULH   = 2'b01;
  localparam logic [1:0] F3_MULHSU = 2'b10;
  localparam logic [1:0] F3_MULHU  = 2'b11;

  function automatic logic rs1_is_signed(input logic [1:0] op);
    return (op == F3_MULH) || (op == F3_MULHSU);
  endfunction

  function automatic logic rs2_is_signed(input logic [1:0] op);
    return (op == F3_MULH);
  endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Iterative radix-2 shift-add multiplier core.
// One multiplier bit per cycle over bits [DATA_W-1:0] of op_b, DATA_W cycles.
// Operands are treated as DATA_W+1-bit sign/zero-extended values; the weight
// of op_b's extension bit (-2^DATA_W) is folded into the accumulator's start
// value, so no extra iteration is needed for signed multipliers.
// Ports:
//   clk, rst_n          clock, async active-low reset (control only)
//   start               load operands and begin iterating (ignored mid-run)
//   a_signed, b_signed  treat op_a / op_b as two's complement
//   op_a, op_b          operands, sampled on start
//   last                high during the final iteration
//   product             accumulator value after the current iteration; equal
//                       to the full product while last is high
module mul_shift_add
  import core_pkg::*;
#(
  parameter int DATA_W = XLEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  a_signed,
  input  logic                  b_signed,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
  output logic                  last,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W);

  logic signed [2*DATA_W-1:0] acc_p0;
  logic signed [2*DATA_W-1:0] mcand_p0;
  logic        [DATA_W-1:0]   mplier_p0;
  logic        [CNT_W-1:0]    cnt;
  logic                       busy;

  logic signed [2*DATA_W-1:0] a_ext;
  logic signed [2*DATA_W-1:0] corr;
  logic signed [2*DATA_W-1:0] step_sum;

  always_comb begin
    a_ext    = {{DATA_W{a_signed & op_a[DATA_W-1]}}, op_a};
    // Negative multiplier: its extension bit carries weight -2^DATA_W
    corr     = (b_signed && op_b[DATA_W-1]) ? -(a_ext <<< DATA_W) : '0;
    step_sum = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
    product  = step_sum;
    last     = busy && (cnt == CNT_W'(DATA_W - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (last) busy <= 1'b0;
    end
  end

  // iteration stage
  always_ff @(posedge clk) begin
    if (start && !busy) begin
      acc_p0    <= corr;
      mcand_p0  <= a_ext;
      mplier_p0 <= op_b;
    end else if (busy) begin
      acc_p0    <= step_sum;
      mcand_p0  <= mcand_p0 <<< 1;
      mplier_p0 <= mplier_p0 >> 1;
    end
  end

endmodule

// File: rtl/mul_unit.sv
// Multiply execution unit (RV32M MUL/MULH/MULHSU/MULHU).
// Accepts an issue in IDLE, collects operands (register file, own last
// result, or forwarded from the ALU/LSU completion buses), runs a 32-cycle
// shift-add and reports the result with a one-cycle mul_done strobe.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   mul_load, funct3, rd, rs1, rs2  issue from scoreboard
//   rs1_data, rs2_data              register-file read data
//   data1_depend, data2_depend      operand producer codes
//   alu_done/rd_alu_update/alu_result, lsu_done/rd_lsu_update/lsu_result
//                                   producer completion buses
//   mul_state                       current FSM state
//   mul_done, rd_mul_update, mul_result  completion report
module mul_unit
  import core_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mul_load,
  input  logic [2:0]           funct3,
  input  logic [REG_IDX_W-1:0] rd,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic [1:0]           data1_depend,
  input  logic [1:0]           data2_depend,
  input  logic                 alu_done,
  input  logic                 lsu_done,
  input  logic [REG_IDX_W-1:0] rd_alu_update,
  input  logic [REG_IDX_W-1:0] rd_lsu_update,
  input  logic [XLEN-1:0]      alu_result,
  input  logic [XLEN-1:0]      lsu_result,
  output logic [1:0]           mul_state,
  output logic                 mul_done,
  output logic [REG_IDX_W-1:0] rd_mul_update,
  output logic [XLEN-1:0]      mul_result
);

  mul_state_e           state, state_nxt;
  logic [1:0]           op_r, op_nxt;
  logic [REG_IDX_W-1:0] rs1_r, rs2_r;
  logic [1:0]           dep1_r, dep2_r;
  logic [XLEN-1:0]      op1_r, op2_r, op1_nxt, op2_nxt;
  logic                 pend1_r, pend2_r, pend1_nxt, pend2_nxt;
  logic                 load_acc;
  logic                 start;
  logic [1:0]           dep1_sel, dep2_sel;
  logic [REG_IDX_W-1:0] rs1_sel, rs2_sel;
  logic [XLEN:0]        snp1, snp2, cap1, cap2;
  logic                 sa_last;
  logic [2*XLEN-1:0]    sa_product;
  logic                 unused_funct3_msb;

  assign unused_funct3_msb = funct3[2];
  assign mul_state         = state;

  // {hit, value}: a producer completes this cycle with the wanted index
  function automatic logic [XLEN:0] snoop(
    input logic [1:0]           dep,
    input logic [REG_IDX_W-1:0] idx,
    input logic                 a_done,
    input logic [REG_IDX_W-1:0] a_rd,
    input logic [XLEN-1:0]      a_res,
    input logic                 l_done,
    input logic [REG_IDX_W-1:0] l_rd,
    input logic [XLEN-1:0]      l_res
  );
    logic [XLEN:0] r;
    r = '0;
    if (dep == DEP_ALU && a_done && a_rd == idx) r = {1'b1, a_res};
    if (dep == DEP_LSU && l_done && l_rd == idx) r = {1'b1, l_res};
    return r;
  endfunction

  // {pending, value} for an operand captured at issue
  function automatic logic [XLEN:0] capture_at_load(
    input logic [1:0]           dep,
    input logic [REG_IDX_W-1:0] idx,
    input logic [XLEN-1:0]      rf,
    input logic [XLEN-1:0]      held,
    input logic [XLEN:0]        snp
  );
    logic [XLEN:0] r;
    r = '0;
    if (idx != '0) begin
      unique case (dep)
        DEP_NONE: r = {1'b0, rf};
        DEP_MUL:  r = {1'b0, held};
        default:  r = snp[XLEN] ? {1'b0, snp[XLEN-1:0]} : {1'b1, {XLEN{1'b0}}};
      endcase
    end
    return r;
  endfunction

  always_comb begin
    dep1_sel = (state == MUL_IDLE) ? data1_depend : dep1_r;
    dep2_sel = (state == MUL_IDLE) ? data2_depend : dep2_r;
    rs1_sel  = (state == MUL_IDLE) ? rs1 : rs1_r;
    rs2_sel  = (state == MUL_IDLE) ? rs2 : rs2_r;
    snp1 = snoop(dep1_sel, rs1_sel, alu_done, rd_alu_update, alu_result,
                 lsu_done, rd_lsu_update, lsu_result);
    snp2 = snoop(dep2_sel, rs2_sel, alu_done, rd_alu_update, alu_result,
                 lsu_done, rd_lsu_update, lsu_result);
    cap1 = capture_at_load(data1_depend, rs1, rs1_data, mul_result, snp1);
    cap2 = capture_at_load(data2_depend, rs2, rs2_data, mul_result, snp2);
  end

  always_comb begin
    state_nxt = state;
    op_nxt    = op_r;
    op1_nxt   = op1_r;
    op2_nxt   = op2_r;
    pend1_nxt = pend1_r;
    pend2_nxt = pend2_r;
    load_acc  = 1'b0;
    start     = 1'b0;
    unique case (state)
      MUL_IDLE: begin
        if (mul_load) begin
          load_acc  = 1'b1;
          op_nxt    = funct3[1:0];
          {pend1_nxt, op1_nxt} = cap1;
          {pend2_nxt, op2_nxt} = cap2;
          if (pend1_nxt || pend2_nxt) begin
            state_nxt = MUL_WAIT_OPS;
          end else begin
            state_nxt = MUL_EXEC;
            start     = 1'b1;
          end
        end
      end
      MUL_WAIT_OPS: begin
        if (pend1_r && snp1[XLEN]) begin
          op1_nxt   = snp1[XLEN-1:0];
          pend1_nxt = 1'b0;
        end
        if (pend2_r && snp2[XLEN]) begin
          op2_nxt   = snp2[XLEN-1:0];
          pend2_nxt = 1'b0;
        end
        if (!pend1_nxt && !pend2_nxt) begin
          state_nxt = MUL_EXEC;
          start     = 1'b1;
        end
      end
      MUL_EXEC: begin
        if (sa_last) state_nxt = MUL_DONE;
      end
      MUL_DONE: state_nxt = MUL_IDLE;
      default:  state_nxt = MUL_IDLE;
    endcase
  end

  // Operands go in from the next-value path so EXEC spans exactly 32 cycles
  mul_shift_add #(
    .DATA_W (XLEN)
  ) u_shift_add (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_signed (rs1_is_signed(op_nxt)),
    .b_signed (rs2_is_signed(op_nxt)),
    .op_a     (op1_nxt),
    .op_b     (op2_nxt),
    .last     (sa_last),
    .product  (sa_product)
  );

  // control / result stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= MUL_IDLE;
      pend1_r       <= 1'b0;
      pend2_r       <= 1'b0;
      mul_done      <= 1'b0;
      rd_mul_update <= '0;
      mul_result    <= '0;
    end else begin
      state    <= state_nxt;
      pend1_r  <= pend1_nxt;
      pend2_r  <= pend2_nxt;
      mul_done <= (state == MUL_EXEC) && sa_last;
      if (load_acc) rd_mul_update <= rd;
      if (state == MUL_EXEC && sa_last)
        mul_result <= (op_r == F3_MUL) ? sa_product[XLEN-1:0] : sa_product[2*XLEN-1:XLEN];
    end
  end

  // operand / issue-field stage
  always_ff @(posedge clk) begin
    op_r  <= op_nxt;
    op1_r <= op1_nxt;
    op2_r <= op2_nxt;
    if (load_acc) begin
      rs1_r  <= rs1;
      rs2_r  <= rs2;
      dep1_r <= data1_depend;
      dep2_r <= data2_depend;
    end
  end

endmodule
